// File: rtl/collision_detect_pkg.sv
// Shared pong definitions used by the collision stage and the Ball stage.
//
// Contents:
//   - screen geometry (HVIS/VVIS), ball size, paddle height, wall thickness
//   - fixed paddle column spans and goal margin
//   - game_state_e : START=00, SERVE=01, PLAY=10, DONE=11
//   - stage1_t     : stage-1 pipeline record of the collision stage
//   - in_span()    : inclusive 11-bit range test
package collision_detect_pkg;

    localparam int unsigned HVIS        = 640;
    localparam int unsigned VVIS        = 480;
    localparam int unsigned BALL_SIZE   = 32;
    localparam int unsigned PADDLE_H    = 80;
    localparam int unsigned WALL        = 8;
    localparam int unsigned GOAL_MARGIN = 16;

    // Paddle columns are fixed; only their vertical position moves.
    localparam logic [10:0] LPAD_X0 = 11'd16;
    localparam logic [10:0] LPAD_X1 = 11'd31;
    localparam logic [10:0] RPAD_X0 = 11'd608;
    localparam logic [10:0] RPAD_X1 = 11'd623;

    typedef enum logic [1:0] {
        ST_START = 2'b00,
        ST_SERVE = 2'b01,
        ST_PLAY  = 2'b10,
        ST_DONE  = 2'b11
    } game_state_e;

    // hits order: {X1, X2, Y1, Y2}
    typedef struct packed {
        logic       obstacle;
        logic [3:0] hits;
        logic       frame;
    } stage1_t;

    function automatic logic in_span(input logic [10:0] x,
                                     input logic [10:0] lo,
                                     input logic [10:0] hi);
        return (x >= lo) && (x <= hi);
    endfunction

endpackage

// File: rtl/collision_detect_obstacle_map.sv
// obstacle_map: combinational test of whether scan pixel (h,v) is an
// obstacle (top/bottom wall or either paddle).
//
// Ports:
//   h_i, v_i     : scan column / row
//   padl_y_i     : top row of the left paddle
//   padr_y_i     : top row of the right paddle
//   obstacle_o   : 1 when (h,v) is a wall or paddle pixel
module obstacle_map #(
    parameter int unsigned PADDLE_H = collision_detect_pkg::PADDLE_H,
    parameter int unsigned WALL     = collision_detect_pkg::WALL,
    parameter int unsigned VVIS     = collision_detect_pkg::VVIS
) (
    input  logic [9:0] h_i,
    input  logic [9:0] v_i,
    input  logic [8:0] padl_y_i,
    input  logic [8:0] padr_y_i,
    output logic       obstacle_o
);
    import collision_detect_pkg::*;

    localparam logic [10:0] PH_W     = 11'(PADDLE_H);
    localparam logic [10:0] WALL_W   = 11'(WALL);
    localparam logic [10:0] WALL_B_W = 11'(VVIS - WALL);

    logic [10:0] h;
    logic [10:0] v;
    logic [10:0] lo_l;
    logic [10:0] hi_l;
    logic [10:0] lo_r;
    logic [10:0] hi_r;
    logic        wall;
    logic        pad_l;
    logic        pad_r;

    assign h    = {1'b0, h_i};
    assign v    = {1'b0, v_i};
    assign lo_l = {2'b00, padl_y_i};
    assign lo_r = {2'b00, padr_y_i};
    // 11 bits hold 511 + PADDLE_H - 1 without wrapping.
    assign hi_l = lo_l + PH_W - 11'd1;
    assign hi_r = lo_r + PH_W - 11'd1;

    // Wall rows count at any column, including rows past the visible area.
    assign wall  = (v < WALL_W) || (v >= WALL_B_W);
    assign pad_l = in_span(h, LPAD_X0, LPAD_X1) && in_span(v, lo_l, hi_l);
    assign pad_r = in_span(h, RPAD_X0, RPAD_X1) && in_span(v, lo_r, hi_r);

    assign obstacle_o = wall || pad_l || pad_r;

endmodule

// File: rtl/collision_detect.sv
// collision_detect: two-stage pixel pipeline that watches the raster scan
// and latches which side of the ball touched a wall or paddle this frame.
//
// Ports:
//   clk, rst          : pixel clock, asynchronous active-low reset
//   state             : game state (START/SERVE/PLAY/DONE)
//   h_cnt, v_cnt      : current scan column / row
//   ballX, ballY      : ball left edge / top edge
//   paddleLY/RY       : top row of left / right paddle
//   CollisionX1/X2    : sticky left / right contact flags
//   CollisionY1/Y2    : sticky top / bottom contact flags
//   ResetCollision    : one-cycle frame-update strobe
//   goalL, goalR      : one-cycle miss pulses, aligned with ResetCollision
//
// Stage 1 registers the obstacle test and the four probe matches for the
// pixel on the inputs; stage 2 folds them into the sticky flags. The frame
// strobe travels through the same two stages so it lines up with the last
// flag update of the frame.
module collision_detect #(
    parameter int unsigned BALL_SIZE = collision_detect_pkg::BALL_SIZE,
    parameter int unsigned PADDLE_H  = collision_detect_pkg::PADDLE_H,
    parameter int unsigned WALL      = collision_detect_pkg::WALL,
    parameter int unsigned HVIS      = collision_detect_pkg::HVIS,
    parameter int unsigned VVIS      = collision_detect_pkg::VVIS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] state,
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    input  logic [9:0] ballX,
    input  logic [8:0] ballY,
    input  logic [8:0] paddleLY,
    input  logic [8:0] paddleRY,
    output logic       CollisionX1,
    output logic       CollisionX2,
    output logic       CollisionY1,
    output logic       CollisionY2,
    output logic       ResetCollision,
    output logic       goalL,
    output logic       goalR
);
    import collision_detect_pkg::*;

    localparam logic [10:0] BS_W   = 11'(BALL_SIZE);
    localparam logic [10:0] HALF_W = 11'(BALL_SIZE / 2);
    localparam logic [10:0] HVIS_W = 11'(HVIS);
    localparam logic [10:0] VVIS_W = 11'(VVIS);
    localparam logic [10:0] GOAL_L = 11'(GOAL_MARGIN);
    localparam logic [10:0] GOAL_R = 11'(HVIS - GOAL_MARGIN);

    // A probe off the visible area never matches, even if the counters
    // happen to reach that position during blanking.
    function automatic logic probe_at(input logic [10:0] px,
                                      input logic [10:0] py,
                                      input logic [10:0] hh,
                                      input logic [10:0] vv);
        return (px < HVIS_W) && (py < VVIS_W) && (px == hh) && (py == vv);
    endfunction

    logic [10:0] h;
    logic [10:0] v;
    logic [10:0] bx;
    logic [10:0] by;
    logic        obs;
    logic        play;
    logic        ball_left;

    stage1_t     s1_d, s1_q;
    logic [3:0]  flags_d, flags_q;  // {X1, X2, Y1, Y2}
    logic        rc_d, rc_q;
    logic        gl_d, gl_q;
    logic        gr_d, gr_q;

    assign h  = {1'b0, h_cnt};
    assign v  = {1'b0, v_cnt};
    assign bx = {1'b0, ballX};
    assign by = {2'b00, ballY};

    obstacle_map #(
        .PADDLE_H (PADDLE_H),
        .WALL     (WALL),
        .VVIS     (VVIS)
    ) u_obstacle_map (
        .h_i        (h_cnt),
        .v_i        (v_cnt),
        .padl_y_i   (paddleLY),
        .padr_y_i   (paddleRY),
        .obstacle_o (obs)
    );

    // Stage 1: obstacle, probe matches and frame position for this pixel.
    always_comb begin
        s1_d          = '0;
        s1_d.obstacle = obs;
        s1_d.hits[3]  = probe_at(bx,                  by + HALF_W,         h, v);
        s1_d.hits[2]  = probe_at(bx + BS_W - 11'd1,   by + HALF_W,         h, v);
        s1_d.hits[1]  = probe_at(bx + HALF_W,         by,                  h, v);
        s1_d.hits[0]  = probe_at(bx + HALF_W,         by + BS_W - 11'd1,   h, v);
        s1_d.frame    = (h == 11'd0) && (v == VVIS_W);
    end

    assign play      = (state == ST_PLAY);
    assign ball_left = (bx < GOAL_L);

    // Stage 2: sticky flags. The cycle after the strobe clears them and the
    // clear beats any set arriving in that same cycle; leaving PLAY also
    // clears them.
    always_comb begin
        flags_d = flags_q;
        if (rc_q || !play) begin
            flags_d = 4'b0000;
        end else if (s1_q.obstacle) begin
            flags_d = flags_q | s1_q.hits;
        end
        rc_d = s1_q.frame;
        gl_d = s1_q.frame && play && ball_left;
        gr_d = s1_q.frame && play && !ball_left && ((bx + BS_W) > GOAL_R);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q    <= '0;
            flags_q <= 4'b0000;
            rc_q    <= 1'b0;
            gl_q    <= 1'b0;
            gr_q    <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            flags_q <= flags_d;
            rc_q    <= rc_d;
            gl_q    <= gl_d;
            gr_q    <= gr_d;
        end
    end

    assign CollisionX1    = flags_q[3];
    assign CollisionX2    = flags_q[2];
    assign CollisionY1    = flags_q[1];
    assign CollisionY2    = flags_q[0];
    assign ResetCollision = rc_q;
    assign goalL          = gl_q;
    assign goalR          = gr_q;

endmodule

// File: tb/tb_collision_detect.sv
// Testbench for collision_detect. Drives arbitrary scan positions (the
// block does not interpret counter wrap) instead of whole frames.
module tb_collision_detect;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state;
    logic [9:0] h_cnt, v_cnt, ballX;
    logic [8:0] ballY, paddleLY, paddleRY;
    logic       CollisionX1, CollisionX2, CollisionY1, CollisionY2;
    logic       ResetCollision, goalL, goalR;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected {X1,X2,Y1,Y2,ResetCollision,goalL,goalR}
    logic [6:0] exp_q[$];

    // Reference model state: the previous pixel's evaluation plus the
    // currently expected outputs.
    logic       m_obs, m_frame;
    logic [3:0] m_hits, m_flags;
    logic       m_rc, m_gl, m_gr;

    typedef struct {
        string      name;
        logic [1:0] st;
        int         bx, by, pl, pr, ph, pv;
        logic [3:0] exp_flags;   // {X1,X2,Y1,Y2} held in the strobe cycle
        logic       exp_gl, exp_gr;
    } vec_t;

    vec_t vecs[$];

    collision_detect dut (
        .clk            (clk),
        .rst            (rst),
        .state          (state),
        .h_cnt          (h_cnt),
        .v_cnt          (v_cnt),
        .ballX          (ballX),
        .ballY          (ballY),
        .paddleLY       (paddleLY),
        .paddleRY       (paddleRY),
        .CollisionX1    (CollisionX1),
        .CollisionX2    (CollisionX2),
        .CollisionY1    (CollisionY1),
        .CollisionY2    (CollisionY2),
        .ResetCollision (ResetCollision),
        .goalL          (goalL),
        .goalR          (goalR)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic logic m_obstacle(int h, int v, int pl, int pr);
        logic wall, lp, rp;
        wall = (v < 8) || (v >= 472);
        lp   = (h >= 16)  && (h <= 31)  && (v >= pl) && (v < pl + 80);
        rp   = (h >= 608) && (h <= 623) && (v >= pr) && (v < pr + 80);
        return wall || lp || rp;
    endfunction

    function automatic logic m_probe(int px, int py, int h, int v);
        return (px < 640) && (py < 480) && (px == h) && (py == v);
    endfunction

    function automatic logic [6:0] dut_out();
        return {CollisionX1, CollisionX2, CollisionY1, CollisionY2,
                ResetCollision, goalL, goalR};
    endfunction

    task automatic model_reset();
        m_obs = 0; m_frame = 0; m_hits = '0; m_flags = '0;
        m_rc = 0; m_gl = 0; m_gr = 0;
        exp_q.delete();
    endtask

    task automatic check(string name, logic [6:0] got, logic [6:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (X1 X2 Y1 Y2 RC gL gR)",
                     name, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // One pixel per clock: drive at negedge, advance the model, push the
    // expected outputs, then pop and compare just after the next posedge.
    task automatic drive_cycle(int h, int v);
        int         bx, by, pl, pr;
        logic       play;
        logic [3:0] nf;
        logic       ngl, ngr;
        logic [6:0] e;
        @(negedge clk);
        h_cnt = 10'(h);
        v_cnt = 10'(v);
        bx = int'(ballX); by = int'(ballY);
        pl = int'(paddleLY); pr = int'(paddleRY);
        play = (state == 2'b10);
        if (m_rc || !play) nf = 4'b0000;
        else nf = m_flags | (m_obs ? m_hits : 4'b0000);
        ngl = m_frame && play && (bx < 16);
        ngr = m_frame && play && !(bx < 16) && (bx + 32 > 624);
        m_flags = nf; m_rc = m_frame; m_gl = ngl; m_gr = ngr;
        m_obs   = m_obstacle(h, v, pl, pr);
        m_hits  = {m_probe(bx, by + 16, h, v), m_probe(bx + 31, by + 16, h, v),
                   m_probe(bx + 16, by, h, v), m_probe(bx + 16, by + 31, h, v)};
        m_frame = (h == 0) && (v == 480);
        exp_q.push_back({m_flags, m_rc, m_gl, m_gr});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check($sformatf("sb_cycle h=%0d v=%0d", h, v), dut_out(), e);
    endtask

    task automatic set_scene(logic [1:0] st, int bx, int by, int pl, int pr);
        state = st; ballX = 10'(bx); ballY = 9'(by);
        paddleLY = 9'(pl); paddleRY = 9'(pr);
    endtask

    function automatic vec_t mk(string n, logic [1:0] st, int bx, int by,
                                int pl, int pr, int ph, int pv,
                                logic [3:0] f, logic gl, logic gr);
        vec_t r;
        r.name = n; r.st = st; r.bx = bx; r.by = by; r.pl = pl; r.pr = pr;
        r.ph = ph; r.pv = pv; r.exp_flags = f; r.exp_gl = gl; r.exp_gr = gr;
        return r;
    endfunction

    // Scan the probe pixel, then the frame position; the strobe shows two
    // edges after (0,480) together with the frame's flags, and everything
    // is clear one cycle later.
    task automatic run_vec(vec_t t);
        set_scene(t.st, t.bx, t.by, t.pl, t.pr);
        drive_cycle(t.ph, t.pv);
        drive_cycle(100, 100);
        drive_cycle(0, 480);
        drive_cycle(100, 100);
        check({t.name, "_strobe"}, dut_out(),
              {t.exp_flags, 1'b1, t.exp_gl, t.exp_gr});
        drive_cycle(100, 100);
        check({t.name, "_cleared"}, dut_out(), 7'b0000000);
    endtask

    initial begin
        // ---------------- reset ----------------
        rst = 1'b0;
        set_scene(2'b00, 0, 0, 0, 0);
        h_cnt = '0; v_cnt = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", dut_out(), 7'b0000000);
        @(negedge clk);
        rst = 1'b1;

        // ---------------- table-driven vectors ----------------
        vecs.push_back(mk("centre",      2'b10, 304, 224, 300, 300, 304, 240, 4'b0000, 0, 0));
        vecs.push_back(mk("wall_top",    2'b10, 304,   0, 300, 300, 320,   0, 4'b0010, 0, 0));
        vecs.push_back(mk("pad_left",    2'b10,  31, 210, 200, 300,  31, 226, 4'b1000, 0, 0));
        vecs.push_back(mk("goal_l",      2'b10,   8, 224, 300, 300,   8, 240, 4'b0000, 1, 0));
        vecs.push_back(mk("goal_r",      2'b10, 600, 224, 300, 300, 631, 240, 4'b0000, 0, 1));
        vecs.push_back(mk("serve_wall",  2'b01, 304,   0, 300, 300, 320,   0, 4'b0000, 0, 0));
        vecs.push_back(mk("done_wall",   2'b11, 304,   0, 300, 300, 320,   0, 4'b0000, 0, 0));
        vecs.push_back(mk("wall_bot",    2'b10, 304, 448, 300, 300, 320, 479, 4'b0001, 0, 0));
        vecs.push_back(mk("pad_right",   2'b10, 577, 150, 300, 100, 608, 166, 4'b0100, 0, 0));
        vecs.push_back(mk("pad_r_top",   2'b10, 577,  84, 300, 100, 608, 100, 4'b0100, 0, 0));
        vecs.push_back(mk("pad_l_below", 2'b10,  31, 264, 200, 300,  31, 280, 4'b0000, 0, 0));
        vecs.push_back(mk("offscreen",   2'b10, 620, 450, 300, 300, 636, 481, 4'b0000, 0, 1));
        vecs.push_back(mk("wall_row7",   2'b10, 304,   7, 300, 300, 320,   7, 4'b0010, 0, 0));
        vecs.push_back(mk("row8_open",   2'b10, 304,   8, 300, 300, 320,   8, 4'b0000, 0, 0));
        vecs.push_back(mk("goal_l_15",   2'b10,  15, 224, 300, 300,  15, 240, 4'b0000, 1, 0));
        vecs.push_back(mk("no_goal_16",  2'b10,  16, 224, 300, 300,  16, 240, 4'b0000, 0, 0));
        vecs.push_back(mk("no_goal_592", 2'b10, 592, 224, 300, 300, 623, 240, 4'b0000, 0, 0));
        vecs.push_back(mk("goal_r_593",  2'b10, 593, 224, 300, 300, 100, 100, 4'b0000, 0, 1));
        foreach (vecs[i]) run_vec(vecs[i]);

        // ---------------- set lands in the strobe cycle ----------------
        set_scene(2'b10, 304, 0, 300, 300);
        drive_cycle(320, 0);
        drive_cycle(0, 480);
        drive_cycle(100, 100);
        check("late_set_visible", dut_out(), 7'b0010100);
        drive_cycle(100, 100);
        check("late_set_cleared", dut_out(), 7'b0000000);

        // ---------------- clear beats a simultaneous set ----------------
        drive_cycle(0, 480);
        drive_cycle(320, 0);
        check("clr_win_strobe", dut_out(), 7'b0000100);
        drive_cycle(100, 100);
        check("clr_win_flag", dut_out(), 7'b0000000);

        // ---------------- leaving PLAY clears ----------------
        drive_cycle(320, 0);
        drive_cycle(100, 100);
        check("play_set", dut_out(), 7'b0010000);
        state = 2'b01;
        drive_cycle(100, 100);
        check("serve_forces_clear", dut_out(), 7'b0000000);

        // ---------------- reset mid-frame ----------------
        state = 2'b10;
        drive_cycle(320, 0);
        drive_cycle(100, 100);
        check("pre_rst_flag", dut_out(), 7'b0010000);
        @(negedge clk);
        h_cnt = 10'd0; v_cnt = 10'd100;
        #2 rst = 1'b0;
        #1;
        check("rst_async", dut_out(), 7'b0000000);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive_cycle(0, 101);
        drive_cycle(100, 102);
        drive_cycle(100, 103);
        check("post_rst_flag", dut_out(), 7'b0000000);
        drive_cycle(320, 0);
        drive_cycle(100, 100);
        check("post_rst_contact", dut_out(), 7'b0010000);
        drive_cycle(0, 480);
        drive_cycle(100, 100);
        drive_cycle(100, 100);

        // ---------------- random scenes ----------------
        for (int g = 0; g < 30; g++) begin
            logic [1:0] st;
            int bx, by;
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
            bx = $urandom_range(0, 639);
            by = $urandom_range(0, 479);
            set_scene(st, bx, by, $urandom_range(0, 400), $urandom_range(0, 400));
            for (int c = 0; c < 60; c++) begin
                case ($urandom_range(0, 6))
                    0: drive_cycle(bx, by + 16);
                    1: drive_cycle(bx + 31, by + 16);
                    2: drive_cycle(bx + 16, by);
                    3: drive_cycle(bx + 16, by + 31);
                    4: drive_cycle(0, 480);
                    5: drive_cycle($urandom_range(0, 31), $urandom_range(0, 15));
                    default: drive_cycle($urandom_range(0, 700), $urandom_range(0, 520));
                endcase
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
